// File: rtl/minisys_muldiv_if.sv
// minisys_muldiv_if: EXE-stage operation/operand bundle and HI/LO/status return for the mul/div unit.
interface minisys_muldiv_if #(
    parameter int WIDTH = 32
);
    logic op_multE;
    logic op_multuE;
    logic op_divE;
    logic op_divuE;
    logic op_mthiE;
    logic op_mtloE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic flushE;
    logic [WIDTH-1:0] hi_data;
    logic [WIDTH-1:0] lo_data;
    logic busy;
    logic done;
    modport master (
        output op_multE, op_multuE, op_divE, op_divuE, op_mthiE, op_mtloE, srcaE, srcbE, flushE,
        input  hi_data, lo_data, busy, done
    );
    modport slave (
        input  op_multE, op_multuE, op_divE, op_divuE, op_mthiE, op_mtloE, srcaE, srcbE, flushE,
        output hi_data, lo_data, busy, done
    );
endinterface

// File: rtl/minisys_muldiv.sv
// minisys_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with single-cycle MTHI/MTLO.
// Define MULDIV_FAST_MULT_EN to make multiplies complete in one cycle via a combinational multiplier.
module minisys_muldiv #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic clrn,
    minisys_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {Idle, Run} muldivState;
    muldivState state, nextState;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] opnd, hiReg, loReg, magA, magB, divRem, quo, rem;
    logic [2*WIDTH-1:0] acc, nextAcc, mulRes, mulStep, divStep;
    logic [WIDTH:0] mulSum, partial;
    logic isDiv, negRes, negRem, doneReg, ge;
    logic divOp, mulOp, isSigned, negA, negB, startOk, startIter, startFast;
    logic writeHi, writeLo, lastIter, finish;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fastProd, fastRes;
`endif
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= Idle;
        else state <= nextState;
    end
    always_comb begin
        nextState = state == Idle ? (startIter ? Run : Idle) : (bus.flushE || lastIter ? Idle : Run);
    end
    // Decode of the EXE-stage ops; priority div > divu > mult > multu > mthi > mtlo.
    always_comb begin
        divOp = bus.op_divE | bus.op_divuE;
        mulOp = bus.op_multE | bus.op_multuE;
        isSigned = divOp ? bus.op_divE : bus.op_multE;
        negA = isSigned & bus.srcaE[WIDTH-1];
        negB = isSigned & bus.srcbE[WIDTH-1];
        magA = negA ? -bus.srcaE : bus.srcaE;
        magB = negB ? -bus.srcbE : bus.srcbE;
        startOk = state == Idle && !bus.flushE;
`ifdef MULDIV_FAST_MULT_EN
        startIter = startOk & divOp;
        startFast = startOk & !divOp & mulOp;
`else
        startIter = startOk & (divOp | mulOp);
        startFast = 1'b0;
`endif
        writeHi = startOk & !divOp & !mulOp & bus.op_mthiE;
        writeLo = startOk & !divOp & !mulOp & !bus.op_mthiE & bus.op_mtloE;
        lastIter = cnt == CW'(WIDTH - 1);
        finish = state == Run && !bus.flushE && lastIter;
    end
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}; opnd is the other operand.
    always_comb begin
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mulStep = {mulSum, acc[WIDTH-1:1]};
        partial = acc[2*WIDTH-1:WIDTH-1];
        ge = partial >= {1'b0, opnd};
        divRem = ge ? partial[WIDTH-1:0] - opnd : partial[WIDTH-1:0];
        divStep = {divRem, acc[WIDTH-2:0], ge};
        nextAcc = isDiv ? divStep : mulStep;
        mulRes = negRes ? -nextAcc : nextAcc;
        quo = negRes ? -nextAcc[WIDTH-1:0] : nextAcc[WIDTH-1:0];
        rem = negRem ? -nextAcc[2*WIDTH-1:WIDTH] : nextAcc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_FAST_MULT_EN
        fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
        fastRes = (negA ^ negB) ? -fastProd : fastProd;
`endif
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
            opnd <= '0;
            acc <= '0;
            isDiv <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            hiReg <= '0;
            loReg <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= finish | startFast;
            if (startIter) begin
                cnt <= '0;
                opnd <= divOp ? magB : magA;
                acc <= {{WIDTH{1'b0}}, divOp ? magA : magB};
                isDiv <= divOp;
                negRes <= negA ^ negB;
                negRem <= negA;
            end else if (state == Run) begin
                cnt <= bus.flushE ? '0 : cnt + 1'b1;
                acc <= nextAcc;
            end
            if (finish) begin
                hiReg <= isDiv ? rem : mulRes[2*WIDTH-1:WIDTH];
                loReg <= isDiv ? quo : mulRes[WIDTH-1:0];
            end
`ifdef MULDIV_FAST_MULT_EN
            if (startFast) begin
                hiReg <= fastRes[2*WIDTH-1:WIDTH];
                loReg <= fastRes[WIDTH-1:0];
            end
`endif
            if (writeHi) hiReg <= bus.srcaE;
            if (writeLo) loReg <= bus.srcaE;
        end
    end
    assign bus.hi_data = hiReg;
    assign bus.lo_data = loReg;
    assign bus.busy = state == Run;
    assign bus.done = doneReg;
endmodule

// File: tb/tb_minisys_muldiv.sv
// tb_minisys_muldiv: directed self-checking bench for minisys_muldiv (default or MULDIV_FAST_MULT_EN build).
module tb_minisys_muldiv;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MulCyc = 0;
`else
    localparam int MulCyc = 32;
`endif
    typedef struct packed {
        logic [5:0] sel;
        logic [31:0] a, b, hi, lo;
        logic [7:0] cyc;
    } vecT;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int nCmp = 0;
    int nErr = 0;
    always #5 clk = ~clk;
    minisys_muldiv_if #(.WIDTH(32)) bus();
    minisys_muldiv #(.WIDTH(32)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    task automatic clearOps();
        {bus.op_divE, bus.op_divuE, bus.op_multE, bus.op_multuE, bus.op_mthiE, bus.op_mtloE} = 6'b0;
    endtask

    // sel = {div, divu, mult, multu, mthi, mtlo}; returns at the negedge where busy is first seen low
    task automatic runOp(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit midChange);
        logic [31:0] h0, l0;
        {bus.op_divE, bus.op_divuE, bus.op_multE, bus.op_multuE, bus.op_mthiE, bus.op_mtloE} = sel;
        bus.srcaE = a;
        bus.srcbE = b;
        h0 = bus.hi_data;
        l0 = bus.lo_data;
        @(posedge clk);
        #1 clearOps();
        cycles = 0;
        midChange = 0;
        @(negedge clk);
        while (bus.busy && cycles < 100) begin
            if (bus.hi_data !== h0 || bus.lo_data !== l0) midChange = 1;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        nCmp += 4;
        if (bus.hi_data !== 32'h0) begin nErr++; $display("FAIL reset_hi: got %h want 0", bus.hi_data); end
        if (bus.lo_data !== 32'h0) begin nErr++; $display("FAIL reset_lo: got %h want 0", bus.lo_data); end
        if (bus.busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin nErr++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mt();
        bus.op_mthiE = 1'b1;
        bus.op_mtloE = 1'b1;
        bus.srcaE = 32'hAAAA5555;
        @(posedge clk);
        #1 clearOps();
        @(negedge clk);
        nCmp += 3;
        if (bus.hi_data !== 32'hAAAA5555) begin nErr++; $display("FAIL mthi_prio_hi: got %h want aaaa5555", bus.hi_data); end
        if (bus.lo_data !== 32'h0) begin nErr++; $display("FAIL mthi_prio_lo: got %h want 0", bus.lo_data); end
        if (bus.done !== 1'b0) begin nErr++; $display("FAIL mt_done: got %b want 0", bus.done); end
        bus.op_mtloE = 1'b1;
        bus.srcaE = 32'h0BADF00D;
        @(posedge clk);
        #1 clearOps();
        @(negedge clk);
        nCmp += 2;
        if (bus.lo_data !== 32'h0BADF00D) begin nErr++; $display("FAIL mtlo_lo: got %h want 0badf00d", bus.lo_data); end
        if (bus.hi_data !== 32'hAAAA5555) begin nErr++; $display("FAIL mtlo_hi: got %h want aaaa5555", bus.hi_data); end
    endtask

    task automatic test_arith();
        vecT vecs [10] = '{
            '{6'b001000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 8'(MulCyc)},
            '{6'b000100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 8'(MulCyc)},
            '{6'b001000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 8'(MulCyc)},
            '{6'b001000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 8'(MulCyc)},
            '{6'b100000, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd32},
            '{6'b100000, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 8'd32},
            '{6'b010000, 32'd100, 32'd7, 32'd2, 32'd14, 8'd32},
            '{6'b010000, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 8'd32},
            '{6'b100000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 8'd32},
            '{6'b010000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 8'd32}
        };
        int cyc;
        bit mid;
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].sel, vecs[i].a, vecs[i].b, cyc, mid);
            nCmp += 6;
            if (cyc !== int'(vecs[i].cyc)) begin nErr++; $display("FAIL arith%0d_busy_cycles: got %0d want %0d", i, cyc, vecs[i].cyc); end
            if (bus.done !== 1'b1) begin nErr++; $display("FAIL arith%0d_done: got %b want 1", i, bus.done); end
            if (bus.hi_data !== vecs[i].hi) begin nErr++; $display("FAIL arith%0d_hi: got %h want %h", i, bus.hi_data, vecs[i].hi); end
            if (bus.lo_data !== vecs[i].lo) begin nErr++; $display("FAIL arith%0d_lo: got %h want %h", i, bus.lo_data, vecs[i].lo); end
            if (mid !== 1'b0) begin nErr++; $display("FAIL arith%0d_partial_exposed: got %b want 0", i, mid); end
            @(negedge clk);
            if (bus.done !== 1'b0) begin nErr++; $display("FAIL arith%0d_done_pulse: got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_priority();
        int cyc;
        bit mid;
        runOp(6'b011010, 32'd100, 32'd7, cyc, mid);
        nCmp += 3;
        if (cyc !== 32) begin nErr++; $display("FAIL prio_cycles: got %0d want 32", cyc); end
        if (bus.hi_data !== 32'd2) begin nErr++; $display("FAIL prio_hi: got %h want 2", bus.hi_data); end
        if (bus.lo_data !== 32'd14) begin nErr++; $display("FAIL prio_lo: got %h want e", bus.lo_data); end
        @(negedge clk);
    endtask

    task automatic test_flush_idle();
        logic [31:0] h0;
        h0 = bus.hi_data;
        bus.op_divE = 1'b1;
        bus.flushE = 1'b1;
        bus.srcaE = 32'd50;
        bus.srcbE = 32'd3;
        @(posedge clk);
        #1 clearOps();
        bus.flushE = 1'b0;
        @(negedge clk);
        nCmp += 3;
        if (bus.busy !== 1'b0) begin nErr++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin nErr++; $display("FAIL flush_idle_done: got %b want 0", bus.done); end
        if (bus.hi_data !== h0) begin nErr++; $display("FAIL flush_idle_hi: got %h want %h", bus.hi_data, h0); end
    endtask

    task automatic test_flush_run();
        bit sawDone;
        bus.op_mthiE = 1'b1;
        bus.srcaE = 32'h12345678;
        @(posedge clk);
        #1 clearOps();
        @(negedge clk);
        bus.op_mtloE = 1'b1;
        bus.srcaE = 32'hCAFEF00D;
        @(posedge clk);
        #1 clearOps();
        @(negedge clk);
        bus.op_divE = 1'b1;
        bus.srcaE = 32'd100;
        bus.srcbE = 32'd7;
        @(posedge clk);
        #1 clearOps();
        repeat (10) @(posedge clk);
        #1;
        nCmp++;
        if (bus.busy !== 1'b1) begin nErr++; $display("FAIL flush_run_busy_before: got %b want 1", bus.busy); end
        bus.flushE = 1'b1;
        @(posedge clk);
        #1 bus.flushE = 1'b0;
        @(negedge clk);
        nCmp++;
        if (bus.busy !== 1'b0) begin nErr++; $display("FAIL flush_run_busy_after: got %b want 0", bus.busy); end
        sawDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) sawDone = 1;
        end
        nCmp += 3;
        if (sawDone !== 1'b0) begin nErr++; $display("FAIL flush_run_done: got %b want 0", sawDone); end
        if (bus.hi_data !== 32'h12345678) begin nErr++; $display("FAIL flush_run_hi: got %h want 12345678", bus.hi_data); end
        if (bus.lo_data !== 32'hCAFEF00D) begin nErr++; $display("FAIL flush_run_lo: got %h want cafef00d", bus.lo_data); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit mid;
        runOp(6'b010000, 32'd1000, 32'd33, cyc, mid);
        runOp(6'b100000, 32'hFFFFFF9C, 32'd7, cyc, mid);
        nCmp += 4;
        if (cyc !== 32) begin nErr++; $display("FAIL b2b_cycles: got %0d want 32", cyc); end
        if (bus.done !== 1'b1) begin nErr++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        if (bus.lo_data !== 32'hFFFFFFF2) begin nErr++; $display("FAIL b2b_lo: got %h want fffffff2", bus.lo_data); end
        if (bus.hi_data !== 32'hFFFFFFFE) begin nErr++; $display("FAIL b2b_hi: got %h want fffffffe", bus.hi_data); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        bit mid;
        bus.op_mthiE = 1'b1;
        bus.srcaE = 32'h12345678;
        @(posedge clk);
        #1 clearOps();
        @(negedge clk);
        bus.op_divuE = 1'b1;
        bus.srcaE = 32'd100;
        bus.srcbE = 32'd7;
        @(posedge clk);
        #1 clearOps();
        repeat (5) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        nCmp += 4;
        if (bus.hi_data !== 32'h0) begin nErr++; $display("FAIL areset_hi: got %h want 0", bus.hi_data); end
        if (bus.lo_data !== 32'h0) begin nErr++; $display("FAIL areset_lo: got %h want 0", bus.lo_data); end
        if (bus.busy !== 1'b0) begin nErr++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin nErr++; $display("FAIL areset_done: got %b want 0", bus.done); end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        runOp(6'b001000, 32'hFFFFFFFE, 32'h00000003, cyc, mid);
        nCmp += 4;
        if (cyc !== MulCyc) begin nErr++; $display("FAIL post_reset_cycles: got %0d want %0d", cyc, MulCyc); end
        if (bus.done !== 1'b1) begin nErr++; $display("FAIL post_reset_done: got %b want 1", bus.done); end
        if (bus.hi_data !== 32'hFFFFFFFF) begin nErr++; $display("FAIL post_reset_hi: got %h want ffffffff", bus.hi_data); end
        if (bus.lo_data !== 32'hFFFFFFFA) begin nErr++; $display("FAIL post_reset_lo: got %h want fffffffa", bus.lo_data); end
    endtask

    initial begin
        clearOps();
        bus.flushE = 1'b0;
        bus.srcaE = '0;
        bus.srcbE = '0;
        test_reset();
        test_mt();
        test_arith();
        test_priority();
        test_flush_idle();
        test_flush_run();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
